// File: rtl/fft_mag_writer.sv
// fft_mag_writer: streams FFT samples as 16-bit magnitudes into one BRAM frame per FFT frame; FFT_MAG_HALF_EN writes only bins 0..N_BINS/2-1
module fft_mag_writer #(
    parameter int N_BINS = 1024,
    parameter int AW     = $clog2(N_BINS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   fft_data,
    input  logic          fft_valid,
    input  logic          fft_last,
    input  logic          hold,
    output logic [AW-1:0] bram_addr,
    output logic [15:0]   bram_din,
    output logic          bram_we,
    output logic          done,
    output logic          frame_err,
    output logic [7:0]    dropped
);
    typedef enum logic [1:0] {SYNC, ARMED, WRITE} state_t;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_BINS - 1);
`ifdef FFT_MAG_HALF_EN
    localparam logic [AW-1:0] HALF_IDX = AW'(N_BINS / 2 - 1);
`endif
    state_t        state, state_nx;
    logic [AW-1:0] idx, idx_nx, pos, s1_idx;
    logic          wr, fin, err, drop;
    logic          s1_valid, s1_fin, s1_err, s2_fin, s2_err;
    logic [15:0]   re, im, a, b, s1_a, s1_b, hi, lo;
    logic [16:0]   mag;
    assign re  = fft_data[31:16];
    assign im  = fft_data[15:0];
    assign a   = re[15] ? -re : re;
    assign b   = im[15] ? -im : im;
    assign hi  = (s1_a > s1_b) ? s1_a : s1_b;
    assign lo  = (s1_a > s1_b) ? s1_b : s1_a;
    assign mag = {1'b0, hi} + {2'b00, lo[15:1]};
    // Frame tracking: decide per sample whether it is written, at which bin, and how the frame ends
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pos      = (state == ARMED) ? '0 : idx;
        wr       = 1'b0;
        fin      = 1'b0;
        err      = 1'b0;
        drop     = 1'b0;
        if (fft_valid && state == SYNC) begin
            state_nx = fft_last ? ARMED : SYNC;
        end else if (fft_valid && state == ARMED && hold) begin
            drop     = 1'b1;
            state_nx = fft_last ? ARMED : SYNC;
        end else if (fft_valid) begin
            idx_nx   = pos + AW'(1);
`ifdef FFT_MAG_HALF_EN
            wr       = ~pos[AW-1];
            fin      = (pos == HALF_IDX);
`else
            wr       = 1'b1;
            fin      = fft_last && (pos == LAST_IDX);
`endif
            err      = fft_last != (pos == LAST_IDX);
            state_nx = fft_last ? ARMED : (pos == LAST_IDX) ? SYNC : WRITE;
        end
    end
    // Frame state, sample index and saturating drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= SYNC;
            idx     <= '0;
            dropped <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (drop && dropped != 8'hFF) dropped <= dropped + 8'd1;
        end
    end
    // Stage 1: absolute values and per-sample write/outcome flags
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_fin   <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= wr;
            s1_idx   <= pos;
            s1_a     <= a;
            s1_b     <= b;
            s1_fin   <= fin;
            s1_err   <= err;
        end
    end
    // Stage 2: BRAM write port; done/frame_err trail the last write by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            s2_fin    <= 1'b0;
            s2_err    <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bram_we   <= s1_valid;
            bram_addr <= s1_valid ? s1_idx : bram_addr;
            bram_din  <= s1_valid ? (mag[16] ? 16'hFFFF : mag[15:0]) : bram_din;
            s2_fin    <= s1_fin;
            s2_err    <= s1_err;
            done      <= s2_fin;
            frame_err <= s2_err;
        end
    end
endmodule

// File: tb/tb_fft_mag_writer.sv
// tb_fft_mag_writer: directed self-checking bench for fft_mag_writer (default full-frame build)
module tb_fft_mag_writer;
    localparam int N = 1024;
    localparam int AW = 10;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   fft_data = '0;
    logic          fft_valid = 1'b0, fft_last = 1'b0, hold = 1'b0;
    logic [AW-1:0] bram_addr;
    logic [15:0]   bram_din;
    logic          bram_we, done, frame_err;
    logic [7:0]    dropped;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int wq_addr[$], wq_din[$], wq_cyc[$], dq[$], eq[$];

    fft_mag_writer #(.N_BINS(N), .AW(AW)) dut (
        .clock(clock), .reset(reset), .fft_data(fft_data), .fft_valid(fft_valid),
        .fft_last(fft_last), .hold(hold), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_we(bram_we), .done(done), .frame_err(frame_err), .dropped(dropped)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // Record writes and pulses with the cycle they were seen in
    always @(negedge clock) begin
        if (bram_we) begin
            wq_addr.push_back(int'(bram_addr));
            wq_din.push_back(int'(bram_din));
            wq_cyc.push_back(cyc);
        end
        if (done) dq.push_back(cyc);
        if (frame_err) eq.push_back(cyc);
    end

    task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im,
                         input logic last, input logic h, output int p);
        fft_valid = v;
        fft_data  = {re, im};
        fft_last  = last;
        hold      = h;
        p = cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        int p;
        repeat (n) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, p);
    endtask

    task automatic clr;
        wq_addr.delete(); wq_din.delete(); wq_cyc.delete(); dq.delete(); eq.delete();
    endtask

    task automatic send_frame(input int len, input int last_at, input logic [15:0] re,
                              input logic [15:0] im, input logic h0, output int p_end);
        int p;
        for (int i = 0; i < len; i++) begin
            drive(1'b1, re, im, i == last_at, (i == 0) ? h0 : 1'b0, p);
            p_end = p;
        end
    endtask

    function automatic int seq_bad(input int off, input int n, input int din);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (off + i >= wq_addr.size() || wq_addr[off+i] != i || wq_din[off+i] != din) bad++;
        return bad;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        n_cmp++; if (bram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bram_we); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        n_cmp++; if (dropped !== 8'd0) begin n_bad++; $display("FAIL reset_dropped: got %0d want 0", dropped); end
        n_cmp++; if (bram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", bram_addr); end
        n_cmp++; if (bram_din !== 16'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", bram_din); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_sync;
        int p;
        clr();
        send_frame(4, 3, 16'd3, 16'hFFFC, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != 0) begin n_bad++; $display("FAIL sync_writes: got %0d want 0", wq_addr.size()); end
        n_cmp++; if (dq.size() != 0) begin n_bad++; $display("FAIL sync_done: got %0d want 0", dq.size()); end
    endtask

    task automatic test_full_frame;
        int p;
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != N) begin n_bad++; $display("FAIL full_writes: got %0d want %0d", wq_addr.size(), N); end
        n_cmp++; if (seq_bad(0, N, 5) != 0) begin n_bad++; $display("FAIL full_seq: got %0d bad entries want 0", seq_bad(0, N, 5)); end
        n_cmp++; if (dq.size() != 1) begin n_bad++; $display("FAIL full_done_cnt: got %0d want 1", dq.size()); end
        n_cmp++; if ((wq_cyc.size() == N ? wq_cyc[N-1] : -1) != p + 2) begin n_bad++; $display("FAIL full_write_lat: got %0d want %0d", (wq_cyc.size() == N ? wq_cyc[N-1] : -1), p + 2); end
        n_cmp++; if ((dq.size() > 0 ? dq[0] : -1) != p + 3) begin n_bad++; $display("FAIL full_done_lat: got %0d want %0d", (dq.size() > 0 ? dq[0] : -1), p + 3); end
        n_cmp++; if (eq.size() != 0) begin n_bad++; $display("FAIL full_err: got %0d want 0", eq.size()); end
    endtask

    task automatic test_magnitude;
        logic [15:0] mre[5] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFF9};
        logic [15:0] mim[5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0002};
        int exp_din[5] = '{32'hBFFE, 32'hC000, 32'h8000, 0, 8};
        int p;
        clr();
        for (int i = 0; i < N; i++)
            drive(1'b1, i < 5 ? mre[i] : 16'h0, i < 5 ? mim[i] : 16'h0, i == N - 1, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != N) begin n_bad++; $display("FAIL mag_writes: got %0d want %0d", wq_addr.size(), N); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ((wq_din.size() > i ? wq_din[i] : -1) != exp_din[i]) begin n_bad++; $display("FAIL mag_%0d: got %h want %h", i, (wq_din.size() > i ? wq_din[i] : -1), exp_din[i]); end
        end
        n_cmp++; if (dq.size() != 1) begin n_bad++; $display("FAIL mag_done: got %0d want 1", dq.size()); end
    endtask

    task automatic test_back_to_back;
        int p1, p2;
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b0, p1);
        send_frame(N, N - 1, 16'd0, 16'd7, 1'b0, p2);
        idle(5);
        n_cmp++; if (wq_addr.size() != 2 * N) begin n_bad++; $display("FAIL b2b_writes: got %0d want %0d", wq_addr.size(), 2 * N); end
        n_cmp++; if (seq_bad(N, N, 7) != 0) begin n_bad++; $display("FAIL b2b_seq: got %0d bad entries want 0", seq_bad(N, N, 7)); end
        n_cmp++; if (dq.size() != 2) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d want 2", dq.size()); end
        n_cmp++; if ((dq.size() == 2 ? dq[1] : -1) != p2 + 3) begin n_bad++; $display("FAIL b2b_done_lat: got %0d want %0d", (dq.size() == 2 ? dq[1] : -1), p2 + 3); end
        n_cmp++; if ((dq.size() > 0 ? dq[0] : -1) != p1 + 3) begin n_bad++; $display("FAIL b2b_done0_lat: got %0d want %0d", (dq.size() > 0 ? dq[0] : -1), p1 + 3); end
    endtask

    task automatic test_hold;
        int p;
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b1, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != 0) begin n_bad++; $display("FAIL hold_writes: got %0d want 0", wq_addr.size()); end
        n_cmp++; if (dropped !== 8'd1) begin n_bad++; $display("FAIL hold_dropped1: got %0d want 1", dropped); end
        n_cmp++; if (dq.size() != 0) begin n_bad++; $display("FAIL hold_done: got %0d want 0", dq.size()); end
        clr();
        send_frame(N, N - 1, 16'd1, 16'd1, 1'b0, p);
        idle(5);
        n_cmp++; if (seq_bad(0, N, 1) != 0 || wq_addr.size() != N) begin n_bad++; $display("FAIL hold_next_frame: got %0d writes want %0d", wq_addr.size(), N); end
        n_cmp++; if (dq.size() != 1) begin n_bad++; $display("FAIL hold_next_done: got %0d want 1", dq.size()); end
        for (int k = 0; k < 299; k++) send_frame(2, 1, 16'd1, 16'd1, 1'b1, p);
        idle(5);
        n_cmp++; if (dropped !== 8'd255) begin n_bad++; $display("FAIL hold_saturate: got %0d want 255", dropped); end
        n_cmp++; if (eq.size() != 0) begin n_bad++; $display("FAIL hold_err: got %0d want 0", eq.size()); end
    endtask

    task automatic test_short_frame;
        int p;
        clr();
        send_frame(501, 500, 16'd2, 16'd2, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != 501 || seq_bad(0, 501, 3) != 0) begin n_bad++; $display("FAIL short_writes: got %0d want 501", wq_addr.size()); end
        n_cmp++; if ((eq.size() == 1 ? eq[0] : -1) != p + 3) begin n_bad++; $display("FAIL short_err: got %0d want %0d", (eq.size() == 1 ? eq[0] : -1), p + 3); end
        n_cmp++; if (dq.size() != 0) begin n_bad++; $display("FAIL short_done: got %0d want 0", dq.size()); end
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != N || dq.size() != 1) begin n_bad++; $display("FAIL short_recover: got %0d writes %0d done want %0d 1", wq_addr.size(), dq.size(), N); end
    endtask

    task automatic test_long_frame;
        int p, q;
        clr();
        send_frame(N, -1, 16'd4, 16'd0, 1'b0, p);
        send_frame(10, 9, 16'd4, 16'd0, 1'b0, q);
        idle(5);
        n_cmp++; if (wq_addr.size() != N || seq_bad(0, N, 4) != 0) begin n_bad++; $display("FAIL long_writes: got %0d want %0d", wq_addr.size(), N); end
        n_cmp++; if ((eq.size() == 1 ? eq[0] : -1) != p + 3) begin n_bad++; $display("FAIL long_err: got %0d want %0d", (eq.size() == 1 ? eq[0] : -1), p + 3); end
        n_cmp++; if (dq.size() != 0) begin n_bad++; $display("FAIL long_done: got %0d want 0", dq.size()); end
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != N || dq.size() != 1) begin n_bad++; $display("FAIL long_recover: got %0d writes %0d done want %0d 1", wq_addr.size(), dq.size(), N); end
    endtask

    task automatic test_reset_mid;
        int p;
        clr();
        send_frame(200, -1, 16'd3, 16'hFFFC, 1'b0, p);
        reset = 1'b1;
        drive(1'b1, 16'd3, 16'hFFFC, 1'b0, 1'b0, p);
        idle(3);
        n_cmp++; if (wq_addr.size() != 199) begin n_bad++; $display("FAIL rst_mid_writes: got %0d want 199", wq_addr.size()); end
        n_cmp++; if (bram_we !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_strobes: got we=%b done=%b err=%b want 0", bram_we, done, frame_err); end
        n_cmp++; if (dropped !== 8'd0 || bram_addr !== '0 || bram_din !== 16'h0) begin n_bad++; $display("FAIL rst_mid_values: got dropped=%0d addr=%0d din=%h want 0", dropped, bram_addr, bram_din); end
        reset = 1'b0;
        idle(2);
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != 0 || dq.size() != 0) begin n_bad++; $display("FAIL rst_mid_sync: got %0d writes want 0", wq_addr.size()); end
        clr();
        send_frame(N, N - 1, 16'd3, 16'hFFFC, 1'b0, p);
        idle(5);
        n_cmp++; if (wq_addr.size() != N || dq.size() != 1) begin n_bad++; $display("FAIL rst_mid_resume: got %0d writes %0d done want %0d 1", wq_addr.size(), dq.size(), N); end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_sync();
        test_full_frame();
        test_magnitude();
        test_back_to_back();
        test_hold();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
